// File: rtl/program_loader.sv
// Byte-stream boot loader: parses CMD/ADDR/COUNT frames,
// writes big-endian words to imem/dmem and gates CPU reset.
module program_loader #(
  parameter int INSTR_MEM_SIZE = 64,
  parameter int DATA_MEM_SIZE  = 32,
  parameter int IAW = $clog2(INSTR_MEM_SIZE),
  parameter int DAW = $clog2(DATA_MEM_SIZE)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  output logic           imem_we,
  output logic [IAW-1:0] imem_addr,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [31:0]    mem_wdata,
  output logic           cpu_reset,
  output logic           busy,
  output logic           error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_RUN
  } state_t;

  localparam logic [7:0] C_IMEM = 8'h01;
  localparam logic [7:0] C_DMEM = 8'h02;
  localparam logic [7:0] C_RUN  = 8'h03;
  localparam logic [7:0] C_HALT = 8'h04;

  localparam logic [8:0] ISZ = 9'(INSTR_MEM_SIZE);
  localparam logic [8:0] DSZ = 9'(DATA_MEM_SIZE);

  state_t state;
  state_t nxt;

  logic        tgt;
  logic [7:0]  widx;
  logic [7:0]  rem;
  logic [1:0]  bcnt;
  logic [31:0] asm_q;

  logic        accept;
  logic        err_set;
  logic [8:0]  sum;
  logic [8:0]  lim;
  logic        cnt_ok;
  logic [31:0] word;

  logic           in_ready_d;
  logic           imem_we_d;
  logic           dmem_we_d;
  logic [IAW-1:0] imem_addr_d;
  logic [DAW-1:0] dmem_addr_d;
  logic [31:0]    mem_wdata_d;
  logic           cpu_reset_d;
  logic           busy_d;
  logic           error_d;

  assign accept = in_valid & in_ready;
  assign sum    = {1'b0, widx} + {1'b0, in_data};
  assign lim    = tgt ? DSZ : ISZ;
  assign cnt_ok = (in_data != 8'd0) && (sum <= lim);
  assign word   = {asm_q[23:0], in_data};

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      imem_we   <= 1'b0;
      dmem_we   <= 1'b0;
      imem_addr <= '0;
      dmem_addr <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= nxt;
      in_ready  <= in_ready_d;
      imem_we   <= imem_we_d;
      dmem_we   <= dmem_we_d;
      imem_addr <= imem_addr_d;
      dmem_addr <= dmem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_reset <= cpu_reset_d;
      busy      <= busy_d;
      error     <= error_d;
    end
  end

  // Next-state decode and error detection
  always_comb begin
    nxt     = state;
    err_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          case (in_data)
            C_IMEM,
            C_DMEM:  nxt = S_ADDR;
            C_RUN:   nxt = S_RUN;
            C_HALT:  nxt = S_IDLE;
            default: err_set = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (accept) nxt = S_COUNT;
      end
      S_COUNT: begin
        if (accept) begin
          if (cnt_ok) begin
            nxt = S_DATA;
          end else begin
            nxt     = S_IDLE;
            err_set = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (accept && bcnt == 2'd3) nxt = S_WRITE;
      end
      S_WRITE: begin
        nxt = (rem != 8'd1) ? S_DATA : S_IDLE;
      end
      S_RUN: begin
        if (accept) begin
          if (in_data == C_HALT) nxt = S_IDLE;
          else err_set = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    in_ready_d  = (nxt != S_WRITE);
    busy_d      = (nxt != S_IDLE) && (nxt != S_RUN);
    cpu_reset_d = (nxt == S_RUN);
    imem_we_d   = (nxt == S_WRITE) && !tgt;
    dmem_we_d   = (nxt == S_WRITE) && tgt;
    error_d     = error | err_set;
    imem_addr_d = imem_addr;
    dmem_addr_d = dmem_addr;
    mem_wdata_d = mem_wdata;
    if (nxt == S_WRITE) begin
      mem_wdata_d = word;
      if (tgt) dmem_addr_d = widx[DAW-1:0];
      else imem_addr_d = widx[IAW-1:0];
    end
  end

  // Frame datapath: target, word index, count, byte assembly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tgt   <= 1'b0;
      widx  <= '0;
      rem   <= '0;
      bcnt  <= '0;
      asm_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept && (in_data == C_IMEM || in_data == C_DMEM))
            tgt <= (in_data == C_DMEM);
        end
        S_ADDR: begin
          if (accept) widx <= in_data;
        end
        S_COUNT: begin
          if (accept) begin
            rem  <= in_data;
            bcnt <= 2'd0;
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_q <= word;
            bcnt  <= bcnt + 2'd1;
          end
        end
        S_WRITE: begin
          widx <= widx + 8'd1;
          rem  <= rem - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus random
// frames checked against a frame-level reference model.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic        dmem_we;
  logic [4:0]  dmem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        error;

  program_loader dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .error     (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          mem;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          exp_run = 0;
  bit          exp_err = 0;
  int          n_fourth = 0;
  int          n_chk = 0;
  int          n_iw = 0;
  int          n_dw = 0;
  int          last_addr = -1;
  logic [31:0] last_data = '0;
  logic [31:0] wbuf[256];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clock) begin
    wr_t e;
    if (!reset) begin
      chk("rst_ctl", {26'd0, in_ready, imem_we, dmem_we,
                      busy, error, cpu_reset}, 32'd0);
      chk("rst_addr", {21'd0, imem_addr, dmem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
    end else begin
      chk("cpu_reset", 32'(cpu_reset), 32'(exp_run));
      chk("error", 32'(error), 32'(exp_err));
      chk("we_excl", 32'(imem_we & dmem_we), 32'd0);
      if (n_fourth != n_chk || imem_we || dmem_we) begin
        if (q.size() == 0) begin
          chk("unexpected_we", {30'd0, imem_we, dmem_we}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("we_timing", {30'd0, imem_we, dmem_we},
              e.mem ? 32'd1 : 32'd2);
          if (e.mem) chk("dmem_addr", 32'(dmem_addr), 32'(e.addr));
          else chk("imem_addr", 32'(imem_addr), 32'(e.addr));
          chk("wdata", mem_wdata, e.data);
          chk("busy_wr", 32'(busy), 32'd1);
        end
        if (imem_we) n_iw++;
        if (dmem_we) n_dw++;
        last_addr = imem_we ? int'(imem_addr) : int'(dmem_addr);
        last_data = mem_wdata;
        n_chk = n_fourth;
      end
    end
  end

  // Offer one byte after gap idle cycles; return at edge+1
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      repeat (gap) @(posedge clock);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    forever begin
      @(posedge clock);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        chk("ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(0, 3)) : g;
  endfunction

  // Load frame: words come from wbuf[0..cnt-1]
  task automatic send_frame(input logic [7:0] cmd, input int addr,
                            input int cnt, input int gap);
    int  size;
    bit  ok;
    size = (cmd == 8'h02) ? 32 : 64;
    ok = (cnt >= 1) && (addr + cnt <= size);
    send_byte(cmd, pick_gap(gap));
    chk("busy_cmd", 32'(busy), 32'd1);
    send_byte(8'(addr), pick_gap(gap));
    send_byte(8'(cnt), pick_gap(gap));
    if (!ok) begin
      exp_err = 1'b1;
      chk("busy_badcnt", 32'(busy), 32'd0);
      return;
    end
    chk("busy_cnt", 32'(busy), 32'd1);
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < 4; k++)
        send_byte(wbuf[i][31-8*k -: 8], pick_gap(gap));
      q.push_back('{mem: (cmd == 8'h02), addr: addr + i,
                    data: wbuf[i]});
      n_fourth++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_err = 1'b0;
    exp_run = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int n0;
    int a;
    int c;
    logic [7:0] b;

    repeat (2) @(posedge clock);
    #1;
    chk("ready_in_reset", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);

    // imem load of two words
    wbuf[0] = 32'h8C01_0000;
    wbuf[1] = 32'hAC02_0004;
    send_frame(8'h01, 0, 2, 0);
    settle();
    chk("imem_count", 32'(n_iw), 32'd2);
    chk("imem_last_addr", 32'(last_addr), 32'd1);
    chk("imem_last_data", last_data, 32'hAC02_0004);
    chk("busy_after", 32'(busy), 32'd0);
    chk("err_after", 32'(error), 32'd0);

    // dmem load with 3-cycle gaps
    wbuf[0] = 32'h0000_001C;
    send_frame(8'h02, 8, 1, 3);
    settle();
    chk("dmem_count", 32'(n_dw), 32'd1);
    chk("dmem_addr_lit", 32'(last_addr), 32'd8);
    chk("dmem_data_lit", last_data, 32'd28);
    chk("no_imem", 32'(n_iw), 32'd2);

    // run / bad byte / halt
    send_byte(8'h03, 0);
    exp_run = 1'b1;
    chk("run_edge", 32'(cpu_reset), 32'd1);
    send_byte(8'h05, 1);
    exp_err = 1'b1;
    chk("run_bad_err", 32'(error), 32'd1);
    chk("run_stays", 32'(cpu_reset), 32'd1);
    chk("run_notbusy", 32'(busy), 32'd0);
    send_byte(8'h04, 1);
    exp_run = 1'b0;
    chk("halt_edge", 32'(cpu_reset), 32'd0);

    // bounds
    do_reset();
    n0 = n_iw;
    send_frame(8'h01, 63, 2, 0);
    settle();
    chk("bound_err", 32'(error), 32'd1);
    chk("bound_nowr", 32'(n_iw), 32'(n0));
    chk("bound_idle", 32'(busy), 32'd0);
    wbuf[0] = 32'hDEAD_BEEF;
    send_frame(8'h01, 63, 1, 0);
    settle();
    chk("top_addr", 32'(last_addr), 32'd63);
    chk("top_data", last_data, 32'hDEAD_BEEF);

    // bad command, sticky error
    do_reset();
    send_byte(8'h7E, 0);
    exp_err = 1'b1;
    chk("badcmd_err", 32'(error), 32'd1);
    chk("badcmd_idle", 32'(busy), 32'd0);
    wbuf[0] = 32'h1234_5678;
    send_frame(8'h02, 0, 1, 0);
    settle();
    chk("sticky_err", 32'(error), 32'd1);
    chk("sticky_data", last_data, 32'h1234_5678);

    // reset mid-word
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b0;
    exp_err = 1'b0;
    exp_run = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    wbuf[0] = 32'hCAFE_F00D;
    send_frame(8'h01, 16, 1, 0);
    settle();
    chk("post_rst_addr", 32'(last_addr), 32'd16);
    chk("post_rst_data", last_data, 32'hCAFE_F00D);

    // random traffic
    do_reset();
    for (int op = 0; op < 250; op++) begin
      if (exp_run) begin
        if ($urandom_range(0, 2) == 0) begin
          b = 8'($urandom_range(5, 255));
          send_byte(b, pick_gap(-1));
          exp_err = 1'b1;
        end else begin
          send_byte(8'h04, pick_gap(-1));
          exp_run = 1'b0;
        end
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5, 6: begin
            b = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            a = int'($urandom_range(0, (b == 8'h01) ? 66 : 34));
            c = int'($urandom_range(0, 4));
            for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
            send_frame(b, a, c, -1);
          end
          7: begin
            send_byte(8'h03, pick_gap(-1));
            exp_run = 1'b1;
          end
          8: begin
            b = ($urandom_range(0, 3) == 0) ? 8'h00
                : 8'($urandom_range(5, 255));
            send_byte(b, pick_gap(-1));
            exp_err = 1'b1;
          end
          default: send_byte(8'h04, pick_gap(-1));
        endcase
      end
    end

    repeat (10) @(posedge clock);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Hardware boot loader for the five-stage MIPS CPU. It receives a byte stream over a valid/ready interface and assembles big-endian 32-bit words. It writes them into instruction memory or data memory through dedicated write ports. It holds the CPU in reset until a run command arrives. This replaces simulation-only `$readmemb` loading with a synthesizable path, so the same program images can be loaded on hardware.

## Interface
Parameters:
- INSTR_MEM_SIZE, 64, instruction memory depth in words
- DATA_MEM_SIZE, 32, data memory depth in words
- IAW, $clog2(INSTR_MEM_SIZE), instruction word-address width
- DAW, $clog2(DATA_MEM_SIZE), data word-address width

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; a transfer happens when in_valid && in_ready
- imem_we  output  1  one-cycle instruction memory write strobe
- imem_addr  output  IAW  instruction memory word index
- dmem_we  output  1  one-cycle data memory write strobe
- dmem_addr  output  DAW  data memory word index
- mem_wdata  output  32  write data shared by both memories
- cpu_reset  output  1  active-low reset to CPU; 0 holds the CPU in reset
- busy  output  1  a frame is in progress (any state other than IDLE or RUN)
- error  output  1  sticky error flag; cleared only by reset

## Operation
Frame format:
- CMD byte, then ADDR byte (start word index), then COUNT byte (number of words), then 4×COUNT data bytes.
- Data bytes are most-significant first.

Commands:
- 0x01 loads instruction memory.
- 0x02 loads data memory.
- 0x03 means RUN; it has no further bytes.
- 0x04 means HALT; it has no further bytes.
- In IDLE, any other CMD value sets error, the byte is consumed, and the FSM stays in IDLE.

FSM states: IDLE, ADDR, COUNT, DATA, WRITE, RUN.
- IDLE --0x01/0x02--> ADDR, and the target is latched.
- IDLE --0x03--> RUN, and cpu_reset goes to 1.
- IDLE --0x04--> IDLE (no-op).
- ADDR --byte--> COUNT, and the start address is latched.
- COUNT --byte--> DATA if COUNT ≥ 1 and ADDR+COUNT ≤ target memory size. The sum is computed 9 bits wide.
- COUNT otherwise: error is set and the FSM returns to IDLE. Any remaining host bytes are then parsed as commands; this is the host's responsibility.
- DATA: accepts 4 bytes using a 2-bit byte counter and shifts them into a 32-bit assembly register. After the 4th byte it goes to WRITE.
- WRITE: one cycle. The target we is 1, the address is the current word index, and mem_wdata holds the assembled word. Then the word index increments and the remaining count decrements. The FSM goes to DATA if the remaining count is nonzero, otherwise to IDLE.
- RUN: only 0x04 is accepted. 0x04 returns to IDLE with cpu_reset set to 0. Any other byte in RUN sets error, is consumed, and the FSM stays in RUN.

in_ready:
- 1 in IDLE, ADDR, COUNT, DATA and RUN.
- 0 in WRITE and while reset is asserted.

Only the latched target's we ever pulses. imem_we and dmem_we are never high in the same cycle.

## Timing
Reset (reset=0) asynchronously forces:
- state to IDLE
- in_ready, imem_we, dmem_we, busy, error, cpu_reset all to 0
- imem_addr, dmem_addr, mem_wdata all to 0

All outputs are registered. in_ready rises on the first rising edge after reset deasserts.

Write latency:
- The we strobe is high in the cycle immediately following acceptance of a word's 4th byte.
- Peak throughput is 1 word per 5 cycles.
- in_valid gaps stall the FSM in place without losing state.

cpu_reset latency:
- It rises on the edge that accepts 0x03.
- It falls on the edge that accepts 0x04.

Reset asserted mid-frame aborts the frame. Words already written remain in memory. The partial word is discarded.

Address is a word index, so byte address = index×4. The final word of a frame may target index SIZE−1. Wrap-around is impossible because of the COUNT check.

## Test plan
- Load imem: frame 01 00 02, then 8C01_0000, then AC02_0004. Required: imem_we pulses twice, at addr 0 then addr 1, with mem_wdata matching each word; busy=1 throughout the frame; then IDLE with error=0.
- Load dmem with backpressure: frame 02 08 01 00 00 00 1C, with in_valid deasserted for 3 cycles between every byte. Required: a single dmem_we with dmem_addr=8 and mem_wdata=28; imem_we is never high.
- Run/halt: send 03. Required: cpu_reset=1 on the accepting edge. Then send 05: required error=1 and the FSM stays in RUN. Then send 04: required cpu_reset=0 and return to IDLE.
- Bounds: frame 01 3F 02. Required: error=1, return to IDLE, no write. Frame 01 3F 01 followed by 4 bytes: required one write at addr 63.
- Bad command: byte 0x7E in IDLE. Required: error=1, byte consumed, IDLE. The error flag persists through the next good frame.
- Reset mid-word: drop reset after 2 data bytes. Required: all outputs 0 and no we pulse. A subsequent full frame loads correctly.
